// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 register window.
// Optional macro WIN3X3_COORD_EN adds win_row/win_col centre-coordinate outputs.
module window3x3_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         pixel_in,
    input  logic                          pixel_valid,
    input  logic                          frame_start,
    output logic [DATA_WIDTH-1:0]         w0,
    output logic [DATA_WIDTH-1:0]         w1,
    output logic [DATA_WIDTH-1:0]         w2,
    output logic [DATA_WIDTH-1:0]         w3,
    output logic [DATA_WIDTH-1:0]         w4,
    output logic [DATA_WIDTH-1:0]         w5,
    output logic [DATA_WIDTH-1:0]         w6,
    output logic [DATA_WIDTH-1:0]         w7,
    output logic [DATA_WIDTH-1:0]         w8,
    output logic                          win_valid
`ifdef WIN3X3_COORD_EN
    ,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic [CW-1:0]         col;
    logic [CW-1:0]         eff_col;
    logic [RW-1:0]         row;
    logic [RW-1:0]         eff_row;

    // frame_start relabels the current pixel as (0,0) regardless of the counters
    always_comb begin
        eff_col = frame_start ? '0 : col;
        eff_row = frame_start ? '0 : row;
        lb0_rd  = lb0[eff_col];
        lb1_rd  = lb1[eff_col];
    end

    // Line buffers are not reset; row gating keeps stale contents out of valid windows
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lb0[eff_col] <= lb1_rd;
            lb1[eff_col] <= pixel_in;
        end
    end

    // w0..w8 are themselves the column shift registers: w2/w5/w8 take the newest column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            {w0, w1, w2, w3, w4, w5, w6, w7, w8} <= '0;
`ifdef WIN3X3_COORD_EN
            win_row   <= '0;
            win_col   <= '0;
`endif
        end else begin
            win_valid <= pixel_valid && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
            if (pixel_valid) begin
                w0 <= w1;  w1 <= w2;  w2 <= lb0_rd;
                w3 <= w4;  w4 <= w5;  w5 <= lb1_rd;
                w6 <= w7;  w7 <= w8;  w8 <= pixel_in;
`ifdef WIN3X3_COORD_EN
                win_row <= eff_row - 1'b1;
                win_col <= eff_col - 1'b1;
`endif
                if (eff_col == COL_LAST) begin
                    col <= '0;
                    row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
                end else begin
                    col <= eff_col + 1'b1;
                    row <= eff_row;
                end
            end
        end
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen on a small 5x4 image, checked against an image-array model.
module tb_window3x3_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] pixel_in = '0;
    logic          pixel_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic [DW-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic          win_valid;
`ifdef WIN3X3_COORD_EN
    logic [$clog2(H)-1:0] win_row;
    logic [$clog2(W)-1:0] win_col;
`endif

    window3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
        .win_valid(win_valid)
`ifdef WIN3X3_COORD_EN
        , .win_row(win_row), .win_col(win_col)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the image as written so far, plus the raster position of the next pixel
    int            img [H][W];
    int            mrow = 0;
    int            mcol = 0;
    bit            e_valid;
    logic [DW-1:0] e_w [9];
    int            e_row, e_col;
    logic          g_valid;
    logic [DW-1:0] g_w [9];
    int            g_row, g_col;

    task automatic capture();
        g_valid = win_valid;
        g_w = '{w0, w1, w2, w3, w4, w5, w6, w7, w8};
`ifdef WIN3X3_COORD_EN
        g_row = int'(win_row);
        g_col = int'(win_col);
`else
        g_row = 0;
        g_col = 0;
`endif
    endtask

    task automatic idle_cycle();
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        @(posedge clk); #1;
        capture();
    endtask

    task automatic feed(input int val, input bit fs);
        int r, c;
        r = fs ? 0 : mrow;
        c = fs ? 0 : mcol;
        img[r][c] = val;
        e_valid = (r >= 2) && (c >= 2);
        e_row = r - 1;
        e_col = c - 1;
        if (e_valid)
            for (int k = 0; k < 9; k++) e_w[k] = DW'(img[r - 2 + k / 3][c - 2 + k % 3]);
        if (c == W - 1) begin
            mcol = 0;
            mrow = (r == H - 1) ? 0 : r + 1;
        end else begin
            mcol = c + 1;
            mrow = r;
        end
        pixel_in    = DW'(val);
        pixel_valid = 1'b1;
        frame_start = fs;
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        capture();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        capture();
        n_cmp++;
        if (g_valid !== 1'b0) begin n_bad++; $display("FAIL reset win_valid got %b want 0", g_valid); end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (g_w[k] !== '0) begin n_bad++; $display("FAIL reset w%0d got %0d want 0", k, g_w[k]); end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mrow = 0; mcol = 0;
    endtask

    task automatic test_first_frame();
        int pulses = 0;
        int first_idx = -1;
        int first_exp [9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
        int last_exp  [9] = '{12, 13, 14, 22, 23, 24, 32, 33, 34};
        logic [DW-1:0] first_got [9];
        logic [DW-1:0] last_got  [9];
        for (int i = 0; i < W * H; i++) begin
            feed(10 * (i / W) + i % W, i == 0);
            n_cmp++;
            if (g_valid !== e_valid) begin n_bad++; $display("FAIL first_frame valid px%0d got %b want %b", i, g_valid, e_valid); end
            if (g_valid === 1'b1) begin
                pulses++;
                if (first_idx < 0) begin first_idx = i; first_got = g_w; end
                last_got = g_w;
            end
            if (e_valid)
                for (int k = 0; k < 9; k++) begin
                    n_cmp++;
                    if (g_w[k] !== e_w[k]) begin n_bad++; $display("FAIL first_frame px%0d w%0d got %0d want %0d", i, k, g_w[k], e_w[k]); end
                end
        end
        n_cmp++;
        if (first_idx != 12) begin n_bad++; $display("FAIL first_frame first_pulse_idx got %0d want 12", first_idx); end
        n_cmp++;
        if (pulses != 6) begin n_bad++; $display("FAIL first_frame pulses got %0d want 6", pulses); end
        for (int k = 0; k < 9; k++) begin
            n_cmp += 2;
            if (first_got[k] !== DW'(first_exp[k])) begin n_bad++; $display("FAIL first_window w%0d got %0d want %0d", k, first_got[k], first_exp[k]); end
            if (last_got[k] !== DW'(last_exp[k])) begin n_bad++; $display("FAIL last_window w%0d got %0d want %0d", k, last_got[k], last_exp[k]); end
        end
    endtask

    task automatic test_gaps();
        int pulses = 0;
        logic [DW-1:0] prev [9];
        for (int i = 0; i < W * H; i++) begin
            if (i != 0) begin
                int gaps = $urandom_range(1, 3);
                for (int g = 0; g < gaps; g++) begin
                    prev = g_w;
                    idle_cycle();
                    n_cmp++;
                    if (g_valid !== 1'b0) begin n_bad++; $display("FAIL gaps valid_in_gap px%0d got %b want 0", i, g_valid); end
                    for (int k = 0; k < 9; k++) begin
                        n_cmp++;
                        if (g_w[k] !== prev[k]) begin n_bad++; $display("FAIL gaps hold px%0d w%0d got %0d want %0d", i, k, g_w[k], prev[k]); end
                    end
                end
            end
            feed(10 * (i / W) + i % W, i == 0);
            n_cmp++;
            if (g_valid !== e_valid) begin n_bad++; $display("FAIL gaps valid px%0d got %b want %b", i, g_valid, e_valid); end
            if (g_valid === 1'b1) pulses++;
            if (e_valid)
                for (int k = 0; k < 9; k++) begin
                    n_cmp++;
                    if (g_w[k] !== e_w[k]) begin n_bad++; $display("FAIL gaps px%0d w%0d got %0d want %0d", i, k, g_w[k], e_w[k]); end
                end
        end
        n_cmp++;
        if (pulses != 6) begin n_bad++; $display("FAIL gaps pulses got %0d want 6", pulses); end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        int b_exp [9] = '{100, 101, 102, 110, 111, 112, 120, 121, 122};
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < W * H; i++) begin
                feed(100 * f + 10 * (i / W) + i % W, (f == 0) && (i == 0));
                n_cmp++;
                if (g_valid !== e_valid) begin n_bad++; $display("FAIL b2b valid f%0d px%0d got %b want %b", f, i, g_valid, e_valid); end
                if (e_valid)
                    for (int k = 0; k < 9; k++) begin
                        n_cmp++;
                        if (g_w[k] !== e_w[k]) begin n_bad++; $display("FAIL b2b f%0d px%0d w%0d got %0d want %0d", f, i, k, g_w[k], e_w[k]); end
                    end
                if (f == 1 && g_valid === 1'b1) begin
                    for (int k = 0; k < 9; k++) begin
                        n_cmp++;
                        if (g_w[k] < DW'(100)) begin n_bad++; $display("FAIL b2b stale px%0d w%0d got %0d want >=100", i, k, g_w[k]); end
                        if (seen == 0) begin
                            n_cmp++;
                            if (g_w[k] !== DW'(b_exp[k])) begin n_bad++; $display("FAIL b2b first w%0d got %0d want %0d", k, g_w[k], b_exp[k]); end
                        end
                    end
                    seen++;
                end
            end
        n_cmp++;
        if (seen != 6) begin n_bad++; $display("FAIL b2b pulses got %0d want 6", seen); end
    endtask

    task automatic test_reset_midframe();
        int first_exp [9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
        int pulses = 0;
        for (int i = 0; i < 2 * W + 2; i++) feed(10 * (i / W) + i % W, i == 0);
        #3;
        rst_n = 1'b0;
        #1;
        capture();
        n_cmp++;
        if (g_valid !== 1'b0) begin n_bad++; $display("FAIL midreset win_valid got %b want 0", g_valid); end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (g_w[k] !== '0) begin n_bad++; $display("FAIL midreset w%0d got %0d want 0", k, g_w[k]); end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mrow = 0; mcol = 0;
        for (int i = 0; i < W * H; i++) begin
            feed(10 * (i / W) + i % W, 1'b0);
            n_cmp++;
            if (g_valid !== e_valid) begin n_bad++; $display("FAIL refeed valid px%0d got %b want %b", i, g_valid, e_valid); end
            if (e_valid)
                for (int k = 0; k < 9; k++) begin
                    n_cmp++;
                    if (g_w[k] !== e_w[k]) begin n_bad++; $display("FAIL refeed px%0d w%0d got %0d want %0d", i, k, g_w[k], e_w[k]); end
                end
            if (g_valid === 1'b1) begin
                if (pulses == 0)
                    for (int k = 0; k < 9; k++) begin
                        n_cmp++;
                        if (g_w[k] !== DW'(first_exp[k])) begin n_bad++; $display("FAIL refeed first w%0d got %0d want %0d", k, g_w[k], first_exp[k]); end
                    end
                pulses++;
            end
        end
        n_cmp++;
        if (pulses != 6) begin n_bad++; $display("FAIL refeed pulses got %0d want 6", pulses); end
    endtask

    task automatic test_frame_start_mid();
        int first_idx = -1;
        for (int i = 0; i < 2 * W + 3; i++) feed(10 * (i / W) + i % W, i == 0);
        for (int i = 0; i < W * H; i++) begin
            feed(50 + 10 * (i / W) + i % W, i == 0);
            n_cmp++;
            if (g_valid !== e_valid) begin n_bad++; $display("FAIL fsmid valid px%0d got %b want %b", i, g_valid, e_valid); end
            if (e_valid)
                for (int k = 0; k < 9; k++) begin
                    n_cmp++;
                    if (g_w[k] !== e_w[k]) begin n_bad++; $display("FAIL fsmid px%0d w%0d got %0d want %0d", i, k, g_w[k], e_w[k]); end
                end
            if (g_valid === 1'b1 && first_idx < 0) begin
                first_idx = i;
                n_cmp++;
                if (g_w[0] !== DW'(50)) begin n_bad++; $display("FAIL fsmid first w0 got %0d want 50", g_w[0]); end
`ifdef WIN3X3_COORD_EN
                n_cmp += 2;
                if (g_row != 1) begin n_bad++; $display("FAIL fsmid win_row got %0d want 1", g_row); end
                if (g_col != 1) begin n_bad++; $display("FAIL fsmid win_col got %0d want 1", g_col); end
`endif
            end
        end
        n_cmp++;
        if (first_idx != 12) begin n_bad++; $display("FAIL fsmid first_pulse_idx got %0d want 12", first_idx); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * W * H; i++) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                idle_cycle();
                n_cmp++;
                if (g_valid !== 1'b0) begin n_bad++; $display("FAIL random gap_valid px%0d got %b want 0", i, g_valid); end
            end
            feed(int'($urandom_range(0, 255)), (i == 0) || ($urandom_range(0, 29) == 0));
            n_cmp++;
            if (g_valid !== e_valid) begin n_bad++; $display("FAIL random valid px%0d got %b want %b", i, g_valid, e_valid); end
            if (e_valid) begin
                for (int k = 0; k < 9; k++) begin
                    n_cmp++;
                    if (g_w[k] !== e_w[k]) begin n_bad++; $display("FAIL random px%0d w%0d got %0d want %0d", i, k, g_w[k], e_w[k]); end
                end
`ifdef WIN3X3_COORD_EN
                n_cmp++;
                if (g_row != e_row || g_col != e_col) begin
                    n_bad++;
                    $display("FAIL random coord px%0d got (%0d,%0d) want (%0d,%0d)", i, g_row, g_col, e_row, e_col);
                end
`endif
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_first_frame();
        test_gaps();
        test_back_to_back();
        test_reset_midframe();
        test_frame_start_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/window3x3_gen.md
Name: window3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator. Sits directly upstream of the 9-input median filter.
- Accepts one raster-order greyscale pixel per valid cycle and buffers two previous image lines internally.
- Presents the 3x3 window centred one row and one column behind the newest pixel on nine parallel outputs w0..w8. These connect straight to the median filter inputs.

Parameters:
- IMG_WIDTH, 640: pixels per line (>=3); sets line-buffer depth.
- IMG_HEIGHT, 480: lines per frame (>=3).
- DATA_WIDTH, 8: pixel width in bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- pixel_in  input  DATA_WIDTH  incoming pixel, raster order
- pixel_valid  input  1  pixel_in is valid this cycle; no backpressure
- frame_start  input  1  qualified by pixel_valid; marks this pixel as (row 0, col 0)
- w0..w8  output  DATA_WIDTH each  window, row-major; w0 top-left, w4 centre, w8 bottom-right (newest pixel)
- win_valid  output  1  one-cycle pulse; w0..w8 hold a complete window

Behaviour:
- Reset (async assert, sync release): w0..w8 = 0, win_valid = 0, row/col counters = 0, shift registers = 0. Line-buffer RAM contents are not cleared; row gating masks stale data.
- Counters:
  - col counts 0..IMG_WIDTH-1. On an accepted pixel at col IMG_WIDTH-1, col wraps to 0 and row increments.
  - row counts 0..IMG_HEIGHT-1. After the last pixel of row IMG_HEIGHT-1, row wraps to 0, giving an implicit new frame.
- frame_start: pixel_valid && frame_start forces that pixel to be treated as (0,0). Counters then advance from there, i.e. next pixel is (0,1). This overrides any position mid-frame.
- Line buffers LB1 (row r-1) and LB0 (row r-2), each IMG_WIDTH x DATA_WIDTH. On each accepted pixel at column c:
  - read LB1[c] and LB0[c];
  - write LB0[c] <= LB1[c] and LB1[c] <= pixel_in.
  - Read-before-write at the same address is required.
- Three 3-deep column shift registers (top/mid/bottom rows) shift only on pixel_valid. New column = {LB0[c], LB1[c], pixel_in}.
- Window mapping for the pixel accepted at (r,c):
  - w0,w1,w2 = rows r-2, cols c-2,c-1,c
  - w3,w4,w5 = row r-1, same cols
  - w6,w7,w8 = row r, same cols
- Latency: the window for a pixel accepted in cycle N appears on w0..w8 in cycle N+1. win_valid is high in N+1 iff that pixel had r>=2 and c>=2.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). No window straddles a line boundary: col<2 is suppressed. Border pixels are not emitted.
- pixel_valid low: nothing shifts or is written, counters hold, win_valid = 0 next cycle, w0..w8 hold their last values. Arbitrary gaps are legal.
- Reset mid-frame: output state clears immediately. The first post-reset pixel is (0,0) regardless of frame_start.
- Width: counters use $clog2 of the dimension. Data paths are passed through unmodified; no arithmetic on pixels.

Optional Feature:
- Macro WIN3X3_COORD_EN.
- Defined: adds outputs win_row (clog2(IMG_HEIGHT) bits) and win_col (clog2(IMG_WIDTH) bits), registered alongside w0..w8. Each gives the centre (w4) coordinate = (r-1, c-1) of the triggering pixel, valid when win_valid = 1. Both reset to 0.
- Undefined: ports absent; all other behaviour identical.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=4, pixel = 10*row+col, continuous valid, frame_start on first pixel -> first win_valid the cycle after pixel 22; w0..w8 = 0,1,2,10,11,12,20,21,22.
- Same frame, full run -> exactly 6 win_valid pulses. Last window w0..w8 = 12,13,14,22,23,24,32,33,34. No pulse for col 0/1 pixels.
- Same frame with random 1-3 cycle pixel_valid gaps -> identical window sequence. win_valid never high in a cycle following a gap. Outputs stable during gaps.
- Two back-to-back frames, second frame = first +100 -> second frame's first window = 100,101,102,110,111,112,120,121,122. No window contains first-frame data.
- Assert rst_n low mid-row 2 -> outputs 0 in the same cycle, asynchronously. Refeed a full frame after release -> results identical to the first scenario.
- Frame_start asserted at (2,3) mid-frame -> counters restart; no win_valid until new (2,2). With WIN3X3_COORD_EN, first window reports win_row=1, win_col=1.
